// File: rtl/icache_line_fill_pkg.sv
// rtl/icache_line_fill_pkg.sv - shared types and constants for the I-cache line fill path
//   ICacheLine       : one 512-bit I-cache data line as stored in the 512x512 SRAM
//   ICACHE_BUS_W     : memory response beat width
//   ICACHE_BEATS     : beats per line burst
//   ICacheFillState  : fill controller state encoding
package icache_line_fill_pkg;

   localparam int ICACHE_LINE_W = 512;
   localparam int ICACHE_BUS_W  = 128;
   localparam int ICACHE_BEATS  = ICACHE_LINE_W / ICACHE_BUS_W;

   typedef logic [ICACHE_LINE_W-1:0] ICacheLine;

   typedef enum logic [2:0] {
      IFS_IDLE,
      IFS_REQ,
      IFS_DATA,
      IFS_WRITE,
      IFS_DONE,
      IFS_ERR
   } ICacheFillState;

endpackage

// File: rtl/icache_line_fill.sv
// rtl/icache_line_fill.sv - I-cache miss line fill: burst request, beat assembly, single SRAM write
//   rst_i        sync reset, active high
//   clk_i        clock
//   miss_i       fill request (sampled only in IDLE)
//   miss_adr_i   missing byte address
//   busy_o       high whenever not IDLE
//   mem_req_o    burst request, held until mem_gnt_i
//   mem_adr_o    line-aligned burst address
//   mem_gnt_i    burst accepted pulse
//   mem_vld_i    response beat valid
//   mem_dat_i    response beat data
//   mem_err_i    response error, qualified by mem_vld_i
//   wr_o         SRAM write strobe
//   wadr_o       SRAM write index
//   o_o          assembled line to SRAM data input
//   done_o       pulse: line written
//   err_o        pulse: fill aborted
module icache_line_fill
   import icache_line_fill_pkg::*;
#(
   parameter int ADR_W  = 32,
   parameter int BUS_W  = ICACHE_BUS_W,
   parameter int LINE_W = ICACHE_LINE_W,
   parameter int IDX_W  = 9,
   parameter int TMO    = 1023
) (
   input  logic              rst_i,
   input  logic              clk_i,
   input  logic              miss_i,
   input  logic [ADR_W-1:0]  miss_adr_i,
   output logic              busy_o,
   output logic              mem_req_o,
   output logic [ADR_W-1:0]  mem_adr_o,
   input  logic              mem_gnt_i,
   input  logic              mem_vld_i,
   input  logic [BUS_W-1:0]  mem_dat_i,
   input  logic              mem_err_i,
   output logic              wr_o,
   output logic [IDX_W-1:0]  wadr_o,
   output logic [LINE_W-1:0] o_o,
   output logic              done_o,
   output logic              err_o
);

   localparam int BEATS  = LINE_W / BUS_W;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int TMO_W  = $clog2(TMO + 1);

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TMO);

   ICacheFillState    state_q;
   logic [BEAT_W-1:0] beat_q;
   logic [TMO_W-1:0]  tmo_q;
   logic              busy_q, mem_req_q, wr_q, done_q, err_q;
   logic [ADR_W-1:0]  mem_adr_q;
   logic [IDX_W-1:0]  wadr_q;
   logic [LINE_W-1:0] line_q;

   // Byte-offset bits within the line are intentionally dropped.
   logic unused_ofs;
   assign unused_ofs = ^miss_adr_i[5:0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IFS_IDLE;
         beat_q    <= '0;
         tmo_q     <= '0;
         busy_q    <= 1'b0;
         mem_req_q <= 1'b0;
         wr_q      <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         mem_adr_q <= '0;
         wadr_q    <= '0;
         line_q    <= '0;
      end else begin
         // Pulse outputs default low; only the transitions below raise them.
         wr_q   <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IFS_IDLE: begin
               if (miss_i) begin
                  mem_adr_q <= {miss_adr_i[ADR_W-1:6], 6'b0};
                  wadr_q    <= miss_adr_i[IDX_W+5:6];
                  mem_req_q <= 1'b1;
                  busy_q    <= 1'b1;
                  tmo_q     <= '0;
                  state_q   <= IFS_REQ;
               end
            end
            IFS_REQ: begin
               if (mem_gnt_i) begin
                  mem_req_q <= 1'b0;
                  beat_q    <= '0;
                  tmo_q     <= '0;
                  state_q   <= IFS_DATA;
               end else if (tmo_q == TMO_MAX) begin
                  mem_req_q <= 1'b0;
                  err_q     <= 1'b1;
                  state_q   <= IFS_ERR;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            IFS_DATA: begin
               if (mem_vld_i && mem_err_i) begin
                  err_q   <= 1'b1;
                  state_q <= IFS_ERR;
               end else if (mem_vld_i) begin
                  line_q[int'(beat_q)*BUS_W +: BUS_W] <= mem_dat_i;
                  tmo_q <= '0;
                  // Terminal beat detect instead of letting the counter wrap.
                  if (beat_q == LAST_BEAT) begin
                     wr_q    <= 1'b1;
                     state_q <= IFS_WRITE;
                  end else begin
                     beat_q <= beat_q + 1'b1;
                  end
               end else if (tmo_q == TMO_MAX) begin
                  err_q   <= 1'b1;
                  state_q <= IFS_ERR;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            IFS_WRITE: begin
               done_q  <= 1'b1;
               state_q <= IFS_DONE;
            end
            IFS_DONE, IFS_ERR: begin
               busy_q  <= 1'b0;
               state_q <= IFS_IDLE;
            end
            default: begin
               busy_q    <= 1'b0;
               mem_req_q <= 1'b0;
               state_q   <= IFS_IDLE;
            end
         endcase
      end
   end

   assign busy_o    = busy_q;
   assign mem_req_o = mem_req_q;
   assign mem_adr_o = mem_adr_q;
   assign wr_o      = wr_q;
   assign wadr_o    = wadr_q;
   assign o_o       = line_q;
   assign done_o    = done_q;
   assign err_o     = err_q;

endmodule

// File: tb/tb_icache_line_fill.sv
// tb/tb_icache_line_fill.sv - directed self-checking bench for icache_line_fill
module tb_icache_line_fill;

   localparam int TMO = 1023;

   logic         clk = 1'b0;
   logic         rst;
   logic         miss;
   logic [31:0]  miss_adr;
   logic         busy, mem_req;
   logic [31:0]  mem_adr;
   logic         gnt, vld, merr;
   logic [127:0] dat;
   logic         wr, done, err;
   logic [8:0]   wadr;
   logic [511:0] o;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;
   int req_rises = 0;
   logic req_prev = 1'b0;
   logic [511:0] sram [512];

   icache_line_fill dut (
      .rst_i(rst), .clk_i(clk), .miss_i(miss), .miss_adr_i(miss_adr),
      .busy_o(busy), .mem_req_o(mem_req), .mem_adr_o(mem_adr), .mem_gnt_i(gnt),
      .mem_vld_i(vld), .mem_dat_i(dat), .mem_err_i(merr),
      .wr_o(wr), .wadr_o(wadr), .o_o(o), .done_o(done), .err_o(err)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM write port plus event counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (wr) begin
         wr_count++;
         sram[wadr] = o;
      end
      if (mem_req && !req_prev) req_rises++;
      req_prev = mem_req;
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] beat_val(input int tag, input int k);
      logic [31:0] w;
      w = 32'hA000_0000 + 32'(tag * 16 + k);
      return {w, ~w, w ^ 32'h5A5A_5A5A, 32'(k)};
   endfunction

   function automatic logic [511:0] line_val(input int tag);
      return {beat_val(tag, 3), beat_val(tag, 2), beat_val(tag, 1), beat_val(tag, 0)};
   endfunction

   // Stimulus only: full fill with immediate grant and back-to-back beats.
   task automatic run_fill(input logic [31:0] adr, input int tag,
                           output logic [8:0] got_wadr, output logic [511:0] got_line,
                           output bit ok);
      int n;
      miss = 1'b1; miss_adr = adr;
      step;
      miss = 1'b0;
      n = 0;
      while (!mem_req && n < 20) begin step; n++; end
      gnt = 1'b1;
      step;
      gnt = 1'b0;
      for (int k = 0; k < 4; k++) begin
         vld = 1'b1; dat = beat_val(tag, k);
         step;
      end
      vld = 1'b0;
      n = 0;
      while (!wr && n < 20) begin step; n++; end
      ok = wr;
      got_wadr = wadr;
      got_line = o;
      n = 0;
      while (!done && n < 5) begin step; n++; end
      ok = ok && done;
      step;
   endtask

   task automatic test_reset;
      rst = 1'b1; miss = 1'b0; miss_adr = '0; gnt = 1'b0; vld = 1'b0; merr = 1'b0; dat = '0;
      step; step;
      checks++;
      if ({busy, mem_req, wr, done, err} !== 5'b0) begin
         errors++; $display("FAIL reset_ctl got %b exp 00000", {busy, mem_req, wr, done, err});
      end
      checks++;
      if (mem_adr !== 32'h0 || wadr !== 9'h0 || o !== 512'h0) begin
         errors++; $display("FAIL reset_data got adr %h wadr %h exp 0", mem_adr, wadr);
      end
      rst = 1'b0;
      step;
   endtask

   task automatic test_basic_fill;
      int wr0;
      wr0 = wr_count;
      miss = 1'b1; miss_adr = 32'h0000_1234;
      step;
      miss = 1'b0;
      checks++;
      if (mem_req !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL basic_req got req %b busy %b exp 1 1", mem_req, busy);
      end
      checks++;
      if (mem_adr !== 32'h0000_1200) begin
         errors++; $display("FAIL basic_mem_adr got %h exp 00001200", mem_adr);
      end
      gnt = 1'b1;
      step;
      gnt = 1'b0;
      checks++;
      if (mem_req !== 1'b0) begin
         errors++; $display("FAIL basic_req_drop got %b exp 0", mem_req);
      end
      for (int k = 0; k < 4; k++) begin
         vld = 1'b1; dat = beat_val(1, k);
         step;
         if (k < 3) begin
            checks++;
            if (wr !== 1'b0) begin
               errors++; $display("FAIL basic_early_wr beat %0d got %b exp 0", k, wr);
            end
         end
      end
      vld = 1'b0;
      checks++;
      if (wr !== 1'b1 || wadr !== 9'h048) begin
         errors++; $display("FAIL basic_wr got wr %b wadr %h exp 1 048", wr, wadr);
      end
      checks++;
      if (o !== line_val(1)) begin
         errors++; $display("FAIL basic_line got %h exp %h", o, line_val(1));
      end
      step;
      checks++;
      if (done !== 1'b1 || wr !== 1'b0) begin
         errors++; $display("FAIL basic_done got done %b wr %b exp 1 0", done, wr);
      end
      checks++;
      if (sram[9'h048] !== line_val(1)) begin
         errors++; $display("FAIL basic_sram got %h exp %h", sram[9'h048], line_val(1));
      end
      step;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || wr_count - wr0 !== 1) begin
         errors++; $display("FAIL basic_idle got done %b busy %b wrs %0d exp 0 0 1", done, busy, wr_count - wr0);
      end
   endtask

   task automatic test_gaps_and_rebusy;
      int wr0, rq0;
      wr0 = wr_count; rq0 = req_rises;
      miss = 1'b1; miss_adr = 32'h0000_2040;
      step;
      miss = 1'b0;
      gnt = 1'b1; step; gnt = 1'b0;
      vld = 1'b1; dat = beat_val(2, 0); step;
      vld = 1'b1; dat = beat_val(2, 1); step;
      vld = 1'b0;
      miss = 1'b1; miss_adr = 32'h0000_5000;
      step;
      miss = 1'b0;
      step; step;
      vld = 1'b1; dat = beat_val(2, 2); step;
      vld = 1'b0; step;
      vld = 1'b1; dat = beat_val(2, 3); step;
      vld = 1'b0;
      checks++;
      if (wr !== 1'b1 || wadr !== 9'h081 || mem_adr !== 32'h0000_2040) begin
         errors++; $display("FAIL gaps_wr got wr %b wadr %h adr %h exp 1 081 00002040", wr, wadr, mem_adr);
      end
      checks++;
      if (o !== line_val(2)) begin
         errors++; $display("FAIL gaps_line got %h exp %h", o, line_val(2));
      end
      step; step; step; step;
      checks++;
      if (req_rises - rq0 !== 1 || wr_count - wr0 !== 1 || busy !== 1'b0) begin
         errors++; $display("FAIL gaps_single got reqs %0d wrs %0d busy %b exp 1 1 0", req_rises - rq0, wr_count - wr0, busy);
      end
   endtask

   task automatic test_bus_error;
      int wr0;
      logic [8:0] gw; logic [511:0] gl; bit ok;
      wr0 = wr_count;
      miss = 1'b1; miss_adr = 32'h0000_3000;
      step;
      miss = 1'b0;
      gnt = 1'b1; step; gnt = 1'b0;
      vld = 1'b1; dat = beat_val(3, 0); step;
      vld = 1'b1; dat = beat_val(3, 1); step;
      vld = 1'b1; merr = 1'b1; dat = beat_val(3, 2); step;
      vld = 1'b0; merr = 1'b0;
      checks++;
      if (err !== 1'b1 || wr !== 1'b0) begin
         errors++; $display("FAIL berr_pulse got err %b wr %b exp 1 0", err, wr);
      end
      step;
      checks++;
      if (err !== 1'b0 || busy !== 1'b0 || wr_count != wr0) begin
         errors++; $display("FAIL berr_idle got err %b busy %b wrs %0d exp 0 0 0", err, busy, wr_count - wr0);
      end
      run_fill(32'h0000_3000, 4, gw, gl, ok);
      checks++;
      if (!ok || gw !== 9'h0C0 || gl !== line_val(4) || wr_count - wr0 !== 1) begin
         errors++; $display("FAIL berr_refill got ok %0d wadr %h wrs %0d exp 1 0c0 1", ok, gw, wr_count - wr0);
      end
   endtask

   task automatic test_timeout;
      int wr0, got;
      logic req_before;
      wr0 = wr_count; got = -1; req_before = 1'b0;
      miss = 1'b1; miss_adr = 32'h0000_4440;
      step;
      miss = 1'b0;
      for (int i = 0; i < TMO + 10; i++) begin
         req_before = mem_req;
         step;
         if (err) begin got = i; break; end
      end
      checks++;
      if (got != TMO) begin
         errors++; $display("FAIL tmo_cycle got %0d exp %0d", got, TMO);
      end
      checks++;
      if (req_before !== 1'b1 || mem_req !== 1'b0) begin
         errors++; $display("FAIL tmo_req got before %b at_err %b exp 1 0", req_before, mem_req);
      end
      step;
      gnt = 1'b1; step; gnt = 1'b0;
      for (int k = 0; k < 4; k++) begin
         vld = 1'b1; dat = beat_val(5, k); step;
      end
      vld = 1'b0;
      step;
      checks++;
      if (busy !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0 || wr_count != wr0) begin
         errors++; $display("FAIL tmo_late got busy %b req %b done %b wrs %0d exp 0 0 0 0", busy, mem_req, done, wr_count - wr0);
      end
   endtask

   task automatic test_reset_mid_fill;
      int wr0;
      logic [8:0] gw; logic [511:0] gl; bit ok;
      wr0 = wr_count;
      miss = 1'b1; miss_adr = 32'h1234_5680;
      step;
      miss = 1'b0;
      gnt = 1'b1; step; gnt = 1'b0;
      vld = 1'b1; dat = beat_val(6, 0); step;
      vld = 1'b1; dat = beat_val(6, 1); step;
      rst = 1'b1; vld = 1'b1; dat = beat_val(6, 2); step;
      rst = 1'b0;
      checks++;
      if ({busy, mem_req, wr, done, err} !== 5'b0 || mem_adr !== 32'h0 || wadr !== 9'h0 || o !== 512'h0) begin
         errors++; $display("FAIL rst_mid got ctl %b adr %h wadr %h exp 00000 0 0", {busy, mem_req, wr, done, err}, mem_adr, wadr);
      end
      vld = 1'b1; dat = beat_val(6, 3); step;
      step;
      vld = 1'b0;
      step;
      checks++;
      if (busy !== 1'b0 || wr_count != wr0) begin
         errors++; $display("FAIL rst_trailing got busy %b wrs %0d exp 0 0", busy, wr_count - wr0);
      end
      run_fill(32'hFFFF_FFC0, 7, gw, gl, ok);
      checks++;
      if (!ok || gw !== 9'h1FF || mem_adr !== 32'hFFFF_FFC0 || gl !== line_val(7)) begin
         errors++; $display("FAIL rst_wrap got ok %0d wadr %h adr %h exp 1 1ff ffffffc0", ok, gw, mem_adr);
      end
   endtask

   task automatic test_back_to_back;
      miss = 1'b1; miss_adr = 32'h0000_6000;
      step;
      miss = 1'b0;
      gnt = 1'b1; step; gnt = 1'b0;
      for (int k = 0; k < 4; k++) begin
         vld = 1'b1; dat = beat_val(8, k); step;
      end
      vld = 1'b0;
      checks++;
      if (wr !== 1'b1 || wadr !== 9'h180 || o !== line_val(8)) begin
         errors++; $display("FAIL b2b_first got wr %b wadr %h exp 1 180", wr, wadr);
      end
      step;
      miss = 1'b1; miss_adr = 32'h0000_7F80;
      step;
      checks++;
      if (busy !== 1'b0 || mem_req !== 1'b0) begin
         errors++; $display("FAIL b2b_idle got busy %b req %b exp 0 0", busy, mem_req);
      end
      step;
      miss = 1'b0;
      checks++;
      if (mem_req !== 1'b1 || mem_adr !== 32'h0000_7F80) begin
         errors++; $display("FAIL b2b_req got req %b adr %h exp 1 00007f80", mem_req, mem_adr);
      end
      gnt = 1'b1; step; gnt = 1'b0;
      for (int k = 0; k < 4; k++) begin
         vld = 1'b1; dat = beat_val(9, k); step;
      end
      vld = 1'b0;
      checks++;
      if (wr !== 1'b1 || wadr !== 9'h1FE || o !== line_val(9)) begin
         errors++; $display("FAIL b2b_second got wr %b wadr %h exp 1 1fe", wr, wadr);
      end
      step;
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL b2b_done got %b exp 1", done);
      end
      step;
   endtask

   initial begin
      test_reset;
      test_basic_fill;
      test_gaps_and_rebusy;
      test_bus_error;
      test_timeout;
      test_reset_mid_fill;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
